// File: rtl/serial_right_shifter_pkg.sv
// ----------------------------------------------------------------------------
// serial_right_shifter_pkg
//
// Purpose:
//   Shared parameter package for the serial right shifter datapath. It holds
//   the default operand/shift-amount widths and the FSM state encodings, so
//   every file that touches the shifter agrees on them.
//
// Contents:
//   DEFAULT_DATA_BUS_WIDTH  default operand/result width
//   DEFAULT_SHAMT_WIDTH     default shift-amount width
//   STATE_*_ENC             raw encodings of the controller states
//   shifter_state_e         enum type built from those encodings
// ----------------------------------------------------------------------------
package serial_right_shifter_pkg;

    localparam int DEFAULT_DATA_BUS_WIDTH = 32;
    localparam int DEFAULT_SHAMT_WIDTH    = 5;

    localparam logic [1:0] STATE_IDLE_ENC  = 2'd0;
    localparam logic [1:0] STATE_SHIFT_ENC = 2'd1;
    localparam logic [1:0] STATE_DONE_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = STATE_IDLE_ENC,
        ST_SHIFT = STATE_SHIFT_ENC,
        ST_DONE  = STATE_DONE_ENC
    } shifter_state_e;

endpackage

// File: rtl/serial_right_shifter.sv
// ----------------------------------------------------------------------------
// serial_right_shifter
//
// Purpose:
//   Multi-cycle right shifter. A start pulse in IDLE captures an operand, a
//   shift amount and a mode flag; the block then shifts the operand right by
//   one bit per clock until the amount is exhausted and pulses done for one
//   cycle. Logical mode fills with zeros, arithmetic mode replicates the MSB.
//
// Ports:
//   clk        in   single clock, all state changes on its rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   request pulse, only honoured in IDLE
//   shift_in   in   operand, captured on the accepted start
//   shamt      in   unsigned shift amount, captured on the accepted start
//   arith      in   1 = arithmetic (SRA), 0 = logical (SRL), captured on start
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse marking a valid result
//   shift_out  out  result register (the working data register)
// ----------------------------------------------------------------------------
module serial_right_shifter
    import serial_right_shifter_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = DEFAULT_DATA_BUS_WIDTH,
    parameter int SHAMT_WIDTH    = DEFAULT_SHAMT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DATA_BUS_WIDTH-1:0] shift_in,
    input  logic [SHAMT_WIDTH-1:0]    shamt,
    input  logic                      arith,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_BUS_WIDTH-1:0] shift_out
);

    localparam logic [SHAMT_WIDTH-1:0] COUNT_ZERO = '0;
    localparam logic [SHAMT_WIDTH-1:0] COUNT_ONE  = {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};

    shifter_state_e              state_q, state_d;
    logic [DATA_BUS_WIDTH-1:0]   data_q,  data_d;
    logic [SHAMT_WIDTH-1:0]      count_q, count_d;
    logic                        arith_q, arith_d;

    // Bit shifted into the vacated MSB: a copy of the current sign bit in
    // arithmetic mode, zero in logical mode.
    logic                        fill_bit;
    logic [DATA_BUS_WIDTH-1:0]   data_shifted;

    // One-bit shift stage, kept inline so the whole datapath lives in this
    // module.
    always_comb begin
        fill_bit     = arith_q & data_q[DATA_BUS_WIDTH-1];
        data_shifted = {fill_bit, data_q[DATA_BUS_WIDTH-1:1]};
    end

    // Next-state and register-update logic. Everything holds by default, so
    // IDLE without start, and the DONE cycle, leave the result untouched
    // until the next accepted request. start is only examined in IDLE, which
    // is what makes requests during SHIFT or DONE vanish instead of queueing.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        arith_d = arith_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_d  = shift_in;
                    count_d = shamt;
                    arith_d = arith;
                    state_d = (shamt != COUNT_ZERO) ? ST_SHIFT : ST_DONE;
                end
            end

            ST_SHIFT: begin
                data_d = data_shifted;
                // The counter is guarded so it can never wrap below zero,
                // even though SHIFT is never entered with a zero count.
                if (count_q != COUNT_ZERO) begin
                    count_d = count_q - COUNT_ONE;
                end
                // Leave on the cycle the counter goes from 1 to 0, which
                // makes the total latency shamt+1 cycles including DONE.
                if (count_q <= COUNT_ONE) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset is synchronous: a low rst_n at the
    // edge wins over anything the next-state logic computed, including a
    // start seen in the same cycle, and clears the datapath so the result
    // output reads zero straight after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            count_q <= '0;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            arith_q <= arith_d;
        end
    end

    // Outputs are pure decodes of the registers, so they are glitch-free
    // and change only on clock edges.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        shift_out = data_q;
    end

endmodule

// File: tb/tb_serial_right_shifter.sv
// ----------------------------------------------------------------------------
// tb_serial_right_shifter
//
// Purpose:
//   Directed self-checking bench for serial_right_shifter. Inputs are driven
//   and outputs sampled on the falling edge; expected values are constants
//   worked out by hand for each vector.
// ----------------------------------------------------------------------------
module tb_serial_right_shifter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] shift_in;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] shift_out;

    int total;
    int bad;

    serial_right_shifter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .shift_in  (shift_in),
        .shamt     (shamt),
        .arith     (arith),
        .busy      (busy),
        .done      (done),
        .shift_out (shift_out)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends even if a wait goes wrong.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it and reports tag/observed/expected on a miss.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Called on a falling edge: presents a request for one cycle, returns on
    // the falling edge of the first cycle after the accepting rising edge.
    task automatic applyStimulus(input logic [31:0] data, input logic [4:0] amt,
                                 input logic mode);
        start    = 1'b1;
        shift_in = data;
        shamt    = amt;
        arith    = mode;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Watches up to budget cycles (the first being the current one) for the
    // done pulse; lat stays 0 if it never arrives.
    task automatic waitDone(input int budget, output int lat, output int busyCycles);
        lat        = 0;
        busyCycles = 0;
        for (int i = 1; i <= budget; i++) begin
            if (i > 1) @(negedge clk);
            if (busy === 1'b1) busyCycles++;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    // Full operation: result, latency, busy length, then post-DONE state.
    task automatic runOp(input string tag, input logic [31:0] data, input logic [4:0] amt,
                         input logic mode, input logic [31:0] expResult, input int expLat);
        int lat;
        int busyCycles;
        applyStimulus(data, amt, mode);
        waitDone(40, lat, busyCycles);
        checkOutput({tag, "_latency"}, lat, expLat);
        checkOutput({tag, "_result"}, shift_out, expResult);
        checkOutput({tag, "_busy_cycles"}, busyCycles, expLat);
        @(negedge clk);
        checkOutput({tag, "_done_low_after"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_result_held"}, shift_out, expResult);
    endtask

    initial begin
        int lat;
        int pulses;
        int busyCycles;

        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        shift_in = '0;
        shamt    = '0;
        arith    = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_shift_out", shift_out, 32'd0);

        // Start together with reset must be dropped, not remembered.
        start    = 1'b1;
        shift_in = 32'hDEADBEEF;
        shamt    = 5'd3;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        checkOutput("start_in_reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("start_in_reset_not_queued", {31'd0, busy}, 32'd0);
        checkOutput("start_in_reset_shift_out", shift_out, 32'd0);

        // Main function across modes, signs and shift-amount boundaries.
        runOp("sra",       32'h80000000, 5'd4,  1'b1, 32'hF8000000, 5);
        runOp("srl",       32'h80000000, 5'd4,  1'b0, 32'h08000000, 5);
        runOp("zero",      32'h1234ABCD, 5'd0,  1'b1, 32'h1234ABCD, 1);
        runOp("max_sra",   32'h80000001, 5'd31, 1'b1, 32'hFFFFFFFF, 32);
        runOp("max_srl",   32'h80000001, 5'd31, 1'b0, 32'h00000001, 32);
        runOp("sra_pos",   32'h7FFFFFFF, 5'd3,  1'b1, 32'h0FFFFFFF, 4);
        runOp("sra_one",   32'hC0000003, 5'd1,  1'b1, 32'hE0000001, 2);
        runOp("srl_mid",   32'h0000F000, 5'd8,  1'b0, 32'h000000F0, 9);

        // IDLE without start holds the result whatever the inputs do.
        shift_in = 32'h55555555;
        shamt    = 5'd7;
        arith    = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_hold_result", shift_out, 32'h000000F0);
        checkOutput("idle_hold_busy", {31'd0, busy}, 32'd0);

        // Overlapping starts, mid-SHIFT (with new operands) and in DONE.
        applyStimulus(32'h80000000, 5'd4, 1'b1);
        pulses = 0;
        lat    = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i > 1) @(negedge clk);
            start = 1'b0;
            if (i == 2) begin
                start    = 1'b1;
                shift_in = 32'h0F0F0F0F;
                shamt    = 5'd1;
                arith    = 1'b0;
            end
            if (done === 1'b1) begin
                pulses++;
                if (lat == 0) begin
                    lat      = i;
                    start    = 1'b1;
                    shift_in = 32'h12345678;
                    shamt    = 5'd2;
                    arith    = 1'b0;
                end
            end
        end
        checkOutput("overlap_latency", lat, 5);
        checkOutput("overlap_done_pulses", pulses, 1);
        checkOutput("overlap_result", shift_out, 32'hF8000000);
        checkOutput("overlap_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of a shift aborts it silently.
        applyStimulus(32'hFFFF0000, 5'd10, 1'b1);
        @(negedge clk);
        checkOutput("abort_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_shift_out", shift_out, 32'd0);
        waitDone(12, lat, busyCycles);
        checkOutput("abort_no_done", lat, 0);
        checkOutput("abort_stays_idle", busyCycles, 0);

        // A fresh request after the abort runs normally.
        runOp("after_abort", 32'h0000F000, 5'd8, 1'b0, 32'h000000F0, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
